// File: rtl/clk_gate_ctrl.sv
// Auto clock-gating sequencer driving the enable of a clock gate cell.
// It gates after a programmable idle run and wakes with a fixed settle time before rdy.
module clk_gate_ctrl #(
   parameter int CNT_W    = 8,
   parameter int WAKE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_bypass,
   input  logic [CNT_W-1:0] cfg_idle_thr,
   input  logic             busy,
   input  logic             req,
   output logic             gate_en,
   output logic             rdy,
   output logic [CNT_W-1:0] gate_cnt
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_OFF  = 2'd1,
      ST_WAKE = 2'd2
   } state_t;

   localparam logic [7:0] WAKE_INIT = 8'(WAKE_CYC);

   state_t           r_state;
   logic [7:0]       r_wake_cnt;
   logic [CNT_W-1:0] r_idle_cnt;
   logic             r_gate_en;
   logic             r_rdy;
   logic [CNT_W-1:0] r_gate_cnt;

   logic             w_activity;
   logic [CNT_W-1:0] w_thr_m1;

   assign w_activity = busy | req;
   // Only used when cfg_idle_thr is nonzero, so the subtraction never wraps.
   assign w_thr_m1   = cfg_idle_thr - CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_WAKE;
         r_wake_cnt <= WAKE_INIT;
         r_idle_cnt <= '0;
         r_gate_en  <= 1'b1;
         r_rdy      <= 1'b0;
         r_gate_cnt <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (w_activity || cfg_bypass || (cfg_idle_thr == '0)) begin
                  r_idle_cnt <= '0;
               end else if (r_idle_cnt >= w_thr_m1) begin
                  r_state    <= ST_OFF;
                  r_gate_en  <= 1'b0;
                  r_rdy      <= 1'b0;
                  r_idle_cnt <= '0;
                  if (r_gate_cnt != '1) begin
                     r_gate_cnt <= r_gate_cnt + CNT_W'(1);
                  end
               end else if (r_idle_cnt != '1) begin
                  r_idle_cnt <= r_idle_cnt + CNT_W'(1);
               end
            end
            ST_OFF: begin
               if (w_activity || cfg_bypass) begin
                  r_state    <= ST_WAKE;
                  r_gate_en  <= 1'b1;
                  r_wake_cnt <= WAKE_INIT;
               end
            end
            ST_WAKE: begin
               // Settle period cannot be aborted; inputs are ignored until RUN.
               if (r_wake_cnt == 8'd1) begin
                  r_state    <= ST_RUN;
                  r_rdy      <= 1'b1;
                  r_idle_cnt <= '0;
               end else begin
                  r_wake_cnt <= r_wake_cnt - 8'd1;
               end
            end
            default: begin
               r_state    <= ST_WAKE;
               r_gate_en  <= 1'b1;
               r_rdy      <= 1'b0;
               r_wake_cnt <= WAKE_INIT;
            end
         endcase
      end
   end

   assign gate_en  = r_gate_en;
   assign rdy      = r_rdy;
   assign gate_cnt = r_gate_cnt;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: the driver queues hand-computed expectations,
// and a monitor compares them against the outputs after each rising edge.
module tb_clk_gate_ctrl;

   logic       clk;
   logic       rst_n;
   logic       cfg_bypass;
   logic [7:0] cfg_idle_thr;
   logic       busy;
   logic       req;
   logic       gate_en;
   logic       rdy;
   logic [7:0] gate_cnt;

   typedef struct {
      logic       ge;
      logic       rd;
      logic [7:0] cnt;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   txn   = 0;

   clk_gate_ctrl #(.CNT_W(8), .WAKE_CYC(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_bypass   (cfg_bypass),
      .cfg_idle_thr (cfg_idle_thr),
      .busy         (busy),
      .req          (req),
      .gate_en      (gate_en),
      .rdy          (rdy),
      .gate_cnt     (gate_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one queued expectation is consumed per rising edge.
   always @(posedge clk) begin
      exp_t e;
      #2;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         txn++;
         $display("txn %0d %s: gate_en=%0b rdy=%0b gate_cnt=%0d", txn, e.nm, gate_en, rdy, gate_cnt);
         total++;
         if (gate_en !== e.ge) begin
            bad++;
            $display("FAIL %s gate_en: got %0b want %0b", e.nm, gate_en, e.ge);
         end
         total++;
         if (rdy !== e.rd) begin
            bad++;
            $display("FAIL %s rdy: got %0b want %0b", e.nm, rdy, e.rd);
         end
         total++;
         if (gate_cnt !== e.cnt) begin
            bad++;
            $display("FAIL %s gate_cnt: got %0d want %0d", e.nm, gate_cnt, e.cnt);
         end
      end
   end

   // Called at a falling edge: apply inputs, queue expected outputs after the next rising edge.
   task automatic step(input logic b, input logic r, input logic byp, input logic [7:0] thr,
                       input logic ege, input logic erd, input logic [7:0] ecnt, input string nm);
      exp_t e;
      busy         = b;
      req          = r;
      cfg_bypass   = byp;
      cfg_idle_thr = thr;
      e.ge  = ege;
      e.rd  = erd;
      e.cnt = ecnt;
      e.nm  = nm;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic chk_now(input logic ege, input logic erd, input logic [7:0] ecnt, input string nm);
      txn++;
      $display("txn %0d %s: gate_en=%0b rdy=%0b gate_cnt=%0d", txn, nm, gate_en, rdy, gate_cnt);
      total++;
      if (gate_en !== ege || rdy !== erd || gate_cnt !== ecnt) begin
         bad++;
         $display("FAIL %s: got ge=%0b rdy=%0b cnt=%0d want ge=%0b rdy=%0b cnt=%0d",
                  nm, gate_en, rdy, gate_cnt, ege, erd, ecnt);
      end
   endtask

   // Asynchronous reset pulse mid-operation; returns at a falling edge with reset released.
   task automatic async_reset(input string nm);
      #2;
      rst_n = 1'b0;
      #1;
      chk_now(1'b1, 1'b0, 8'd0, nm);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int c;
      rst_n        = 1'b0;
      cfg_bypass   = 1'b0;
      cfg_idle_thr = 8'd0;
      busy         = 1'b0;
      req          = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_now(1'b1, 1'b0, 8'd0, "reset_vals");
      rst_n = 1'b1;

      // 1: wake after reset, thr=0 never gates
      step(0, 0, 0, 8'd0, 1, 0, 8'd0, "t1_wake1");
      step(0, 0, 0, 8'd0, 1, 1, 8'd0, "t1_rdy");
      for (int i = 0; i < 3; i++) step(0, 0, 0, 8'd0, 1, 1, 8'd0, "t1_nogate");

      // 2: thr=4, four idle samples gate
      step(1, 0, 0, 8'd4, 1, 1, 8'd0, "t2_busy");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t2_idle1");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t2_idle2");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t2_idle3");
      step(0, 0, 0, 8'd4, 0, 0, 8'd1, "t2_gate");
      step(0, 1, 0, 8'd4, 1, 0, 8'd1, "t2_req");
      step(0, 0, 0, 8'd4, 1, 0, 8'd1, "t2_wake");
      step(0, 0, 0, 8'd4, 1, 1, 8'd1, "t2_run");
      // busy pulse restarts the idle count
      step(0, 0, 0, 8'd4, 1, 1, 8'd1, "t2b_idle1");
      step(0, 0, 0, 8'd4, 1, 1, 8'd1, "t2b_idle2");
      step(1, 0, 0, 8'd4, 1, 1, 8'd1, "t2b_pulse");
      step(0, 0, 0, 8'd4, 1, 1, 8'd1, "t2b_re1");
      step(0, 0, 0, 8'd4, 1, 1, 8'd1, "t2b_re2");
      step(0, 0, 0, 8'd4, 1, 1, 8'd1, "t2b_re3");
      step(0, 0, 0, 8'd4, 0, 0, 8'd2, "t2b_gate");

      // 3: stays off while idle, thr change ignored, req pulse wake
      step(0, 0, 0, 8'd4, 0, 0, 8'd2, "t3_off");
      step(0, 0, 0, 8'd0, 0, 0, 8'd2, "t3_thr0_off");
      step(0, 1, 0, 8'd4, 1, 0, 8'd2, "t3_req");
      step(0, 0, 0, 8'd4, 1, 0, 8'd2, "t3_hold");
      step(0, 0, 0, 8'd4, 1, 1, 8'd2, "t3_rdy");

      // 4: thr=1 gates on first idle sample; bypass wakes and holds
      step(0, 0, 0, 8'd1, 0, 0, 8'd3, "t4_thr1");
      step(0, 0, 1, 8'd1, 1, 0, 8'd3, "t4_byp_wake");
      step(0, 0, 1, 8'd1, 1, 0, 8'd3, "t4_byp_w2");
      step(0, 0, 1, 8'd1, 1, 1, 8'd3, "t4_byp_run");
      for (int i = 0; i < 3; i++) step(0, 0, 1, 8'd1, 1, 1, 8'd3, "t4_byp_hold");
      step(0, 0, 0, 8'd1, 0, 0, 8'd4, "t4_unbyp");

      // 5: lowering thr mid-count gates on the next idle sample
      step(0, 1, 0, 8'd200, 1, 0, 8'd4, "t5_req");
      step(0, 0, 0, 8'd200, 1, 0, 8'd4, "t5_wake");
      step(0, 0, 0, 8'd200, 1, 1, 8'd4, "t5_run");
      for (int i = 0; i < 10; i++) step(0, 0, 0, 8'd200, 1, 1, 8'd4, "t5_count");
      step(0, 0, 0, 8'd3, 0, 0, 8'd5, "t5_lower");

      // 5b: 300 gate events saturate the counter
      c = 5;
      for (int i = 0; i < 300; i++) begin
         step(0, 1, 0, 8'd1, 1, 0, 8'(c), "t5s_req");
         step(0, 0, 0, 8'd1, 1, 0, 8'(c), "t5s_wake");
         step(0, 0, 0, 8'd1, 1, 1, 8'(c), "t5s_run");
         if (c < 255) c++;
         step(0, 0, 0, 8'd1, 0, 0, 8'(c), "t5s_gate");
      end

      // 6: reset mid-WAKE, then mid-RUN idle count
      step(0, 1, 0, 8'd4, 1, 0, 8'd255, "t6_req");
      async_reset("t6_rst_wake");
      step(0, 0, 0, 8'd4, 1, 0, 8'd0, "t6_w1");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t6_run");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t6_idle1");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t6_idle2");
      async_reset("t6_rst_run");
      step(0, 0, 0, 8'd4, 1, 0, 8'd0, "t6b_w1");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t6b_run");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t6b_idle1");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t6b_idle2");
      step(0, 0, 0, 8'd4, 1, 1, 8'd0, "t6b_idle3");
      step(0, 0, 0, 8'd4, 0, 0, 8'd1, "t6b_gate");

      @(posedge clk);
      #4;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
